// File: rtl/rom_loader_pkg.sv
// rom_loader_pkg: shared constants for the streaming ROM loader.
//   - FSM state encodings (IDLE/LEN/DATA/CHK/DONE/ERR)
//   - default frame start marker
//   - number of bytes in the length field / in a data word
package rom_loader_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LEN  = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_CHK  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;
  localparam logic [2:0] ST_ERR  = 3'd5;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int         LEN_BYTES     = 4;

endpackage

// File: rtl/rom_loader_byte_packer.sv
// byte_packer: assembles a little-endian byte stream into 32-bit words.
// Ports:
//   clk, rst_n        clock / async active-low reset
//   clear             restart at lane 0 (frame resync)
//   in_valid, in_data byte accepted this cycle
//   word_valid        combinational: this byte completes a word
//   word              completed word (valid with word_valid)
module byte_packer
  import rom_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  lane;
  logic [31:0] sh;

  // Newest byte enters at the top, so after four shifts the first byte
  // sits in [7:0].
  assign word       = {in_data, sh[31:8]};
  assign word_valid = in_valid && (lane == 2'(LEN_BYTES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane <= '0;
      sh   <= '0;
    end else if (clear) begin
      lane <= '0;
    end else if (in_valid) begin
      lane <= lane + 2'd1;
      sh   <= word;
    end
  end

endmodule

// File: rtl/rom_loader.sv
// rom_loader: writes instruction ROM from a framed byte stream and holds the
// core in reset until the image is complete.
// Frame: SYNC_BYTE, 4-byte little-endian word count N, N*4 data bytes
// (little-endian words), optional trailing mod-256 checksum byte.
// Optional feature macro: ROM_LOADER_CHECKSUM_EN (adds the CHK state).
// Ports:
//   clk, rst_n            clock / async active-low reset
//   boot_sel              1 = load over stream, 0 = bypass (sampled in IDLE)
//   byte_valid/byte_data  input stream; byte_ready is 1 after reset
//   rom_we/rom_waddr/rom_wdata  ROM write port, one-cycle strobe
//   core_rst_n            active-low reset to the core
//   load_done / load_err  sticky status
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int         ADDR_W    = 12,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              boot_sel,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_waddr,
  output logic [31:0]       rom_wdata,
  output logic              core_rst_n,
  output logic              load_done,
  output logic              load_err
);

  localparam logic [32:0] CAP = 33'd1 << ADDR_W;

  logic [2:0]        state;
  logic [ADDR_W:0]   n_words;
  logic [ADDR_W-1:0] word_idx;
  logic              accept, is_sync, sync_clear, pk_valid, pk_wv;
  logic [31:0]       pk_word;
  logic              len_bad, last_word;
`ifdef ROM_LOADER_CHECKSUM_EN
  logic [7:0]        sum;
`endif

  assign accept     = byte_valid && byte_ready;
  assign is_sync    = accept && (byte_data == SYNC_BYTE);
  assign sync_clear = is_sync && ((state == ST_IDLE && boot_sel) || state == ST_ERR);
  // The packer assembles both the length field and the data words.
  assign pk_valid   = accept && (state == ST_LEN || state == ST_DATA);
  assign len_bad    = (pk_word == 32'd0) || ({1'b0, pk_word} > CAP);
  assign last_word  = ({1'b0, word_idx} == n_words - 1'b1);

  byte_packer u_pack (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (sync_clear),
    .in_valid   (pk_valid),
    .in_data    (byte_data),
    .word_valid (pk_wv),
    .word       (pk_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      n_words    <= '0;
      word_idx   <= '0;
      byte_ready <= 1'b0;
      rom_we     <= 1'b0;
      rom_waddr  <= '0;
      rom_wdata  <= '0;
      core_rst_n <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
      sum        <= '0;
`endif
    end else begin
      byte_ready <= 1'b1;
      rom_we     <= 1'b0;
      // Status outputs follow the state one cycle late.
      load_done  <= (state == ST_DONE);
      core_rst_n <= (state == ST_DONE);
      load_err   <= (state == ST_ERR);
      case (state)
        ST_IDLE: begin
          if (!boot_sel) begin
            state <= ST_DONE;
          end else if (is_sync) begin
            state    <= ST_LEN;
            word_idx <= '0;
`ifdef ROM_LOADER_CHECKSUM_EN
            sum      <= '0;
`endif
          end
        end
        ST_LEN: begin
          if (pk_wv) begin
            n_words <= pk_word[ADDR_W:0];
            state   <= len_bad ? ST_ERR : ST_DATA;
          end
        end
        ST_DATA: begin
`ifdef ROM_LOADER_CHECKSUM_EN
          if (accept) sum <= sum + byte_data;
`endif
          if (pk_wv) begin
            rom_we    <= 1'b1;
            rom_waddr <= word_idx;
            rom_wdata <= pk_word;
            word_idx  <= word_idx + 1'b1;
`ifdef ROM_LOADER_CHECKSUM_EN
            if (last_word) state <= ST_CHK;
`else
            if (last_word) state <= ST_DONE;
`endif
          end
        end
`ifdef ROM_LOADER_CHECKSUM_EN
        ST_CHK: begin
          if (accept) state <= (byte_data == sum) ? ST_DONE : ST_ERR;
        end
`endif
        ST_ERR: begin
          if (is_sync) begin
            state    <= ST_LEN;
            word_idx <= '0;
`ifdef ROM_LOADER_CHECKSUM_EN
            sum      <= '0;
`endif
          end
        end
        default: state <= state; // DONE is terminal until rst_n
      endcase
    end
  end

endmodule
